// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  key_conditioner : synchronise, debounce and pulse-decode active-low keys
//  Revision 1.0 - initial release
// ============================================================================
module key_conditioner #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] long_press
);

   localparam int c_cnt_w  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);

   localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);
   localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_CYCLES);

   localparam logic [1:0] c_st_idle         = 2'd0;
   localparam logic [1:0] c_st_press_wait   = 2'd1;
   localparam logic [1:0] c_st_down         = 2'd2;
   localparam logic [1:0] c_st_release_wait = 2'd3;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      logic                r_sync1, r_sync2;
      logic                w_s;
      logic [1:0]          r_state, w_state_nxt;
      logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
      logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
      logic                r_long_done, w_long_done_nxt;
      logic                w_active;
      logic                r_pressed, w_pressed_nxt;
      logic                r_press_pulse, w_press_pulse_nxt;
      logic                r_release_pulse, w_release_pulse_nxt;
      logic                r_long_press, w_long_press_nxt;

      // Synchroniser idles at 1 so a reset looks like a released key
      always_ff @(posedge clk) begin
         if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
         end else begin
            r_sync1 <= key_n[g];
            r_sync2 <= r_sync1;
         end
      end

      assign w_s      = ~r_sync2;
      assign w_active = (r_state == c_st_down) || (r_state == c_st_release_wait);

      always_ff @(posedge clk) begin
         if (reset) begin
            r_state         <= c_st_idle;
            r_cnt           <= '0;
            r_hold_cnt      <= '0;
            r_long_done     <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_press    <= 1'b0;
         end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_long_done     <= w_long_done_nxt;
            r_pressed       <= w_pressed_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_long_press    <= w_long_press_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         case (r_state)
            c_st_idle: begin
               if (w_s) begin
                  w_state_nxt = c_st_press_wait;
                  w_cnt_nxt   = c_cnt_one;
               end
            end
            c_st_press_wait: begin
               if (!w_s) begin
                  w_state_nxt = c_st_idle;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == c_cnt_last) begin
                  w_state_nxt = c_st_down;
               end else begin
                  w_cnt_nxt = r_cnt + c_cnt_one;
               end
            end
            c_st_down: begin
               if (!w_s) begin
                  w_state_nxt = c_st_release_wait;
                  w_cnt_nxt   = c_cnt_one;
               end
            end
            default: begin
               if (w_s) begin
                  w_state_nxt = c_st_down;
               end else if (r_cnt == c_cnt_last) begin
                  w_state_nxt = c_st_idle;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + c_cnt_one;
               end
            end
         endcase
      end

      // Hold timer saturates; the done flag makes long_press one-shot per press
      always_comb begin
         w_pressed_nxt       = (w_state_nxt == c_st_down) || (w_state_nxt == c_st_release_wait);
         w_press_pulse_nxt   = (r_state == c_st_press_wait) && w_s && (r_cnt == c_cnt_last);
         w_release_pulse_nxt = (r_state == c_st_release_wait) && !w_s && (r_cnt == c_cnt_last);
         w_long_press_nxt    = w_active && (r_hold_cnt == c_hold_max) && !r_long_done;
         w_long_done_nxt     = r_long_done || w_long_press_nxt;
         w_hold_nxt          = r_hold_cnt;
         if (w_press_pulse_nxt) begin
            w_hold_nxt = c_hold_one;
         end else if (w_active && (r_hold_cnt != c_hold_max)) begin
            w_hold_nxt = r_hold_cnt + c_hold_one;
         end
         if (w_state_nxt == c_st_idle) begin
            w_hold_nxt      = '0;
            w_long_done_nxt = 1'b0;
         end
      end

      assign pressed[g]       = r_pressed;
      assign press_pulse[g]   = r_press_pulse;
      assign release_pulse[g] = r_release_pulse;
      assign long_press[g]    = r_long_press;
   end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// Scoreboard bench for key_conditioner: expected pulse events are queued by
// the stimulus thread and matched by a monitor that watches every output pulse.
module tb_key_conditioner;

   localparam int NK = 2;
   localparam int D  = 4;
   localparam int H  = 10;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int cyc;
      int key;
      int kind;
   } ev_t;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic [NK-1:0] key_n = 2'b11;
   logic [NK-1:0] pressed, press_pulse, release_pulse, long_press;

   int  cyc      = 0;
   int  checks   = 0;
   int  failures = 0;
   ev_t exp_q[$];

   key_conditioner #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_press   (long_press)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int c, input int k, input int kind);
      ev_t e;
      e.cyc  = c;
      e.key  = k;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   task automatic check_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: every asserted pulse must match the head of the expectation queue
   always @(negedge clk) begin
      for (int k = 0; k < NK; k++) begin
         for (int kind = 0; kind < 3; kind++) begin
            logic p;
            ev_t  e;
            p = (kind == K_PRESS) ? press_pulse[k] :
                (kind == K_REL)   ? release_pulse[k] : long_press[k];
            if (p) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_pulse cyc=%0d key=%0d kind=%0d", cyc, k, kind);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.key != k || e.kind != kind) begin
                     failures++;
                     $display("FAIL pulse_match actual cyc=%0d key=%0d kind=%0d required cyc=%0d key=%0d kind=%0d",
                              cyc, k, kind, e.cyc, e.key, e.kind);
                  end
               end
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int e0, a, f, r, e;

      // Reset state
      repeat (3) @(negedge clk);
      check_vec("rst_pressed", pressed, 2'b00);
      check_vec("rst_press_pulse", press_pulse, 2'b00);
      check_vec("rst_release_pulse", release_pulse, 2'b00);
      check_vec("rst_long_press", long_press, 2'b00);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Clean press on key 1, held long enough for a single long press
      key_n[1] = 1'b0;
      e0 = cyc + 1;
      expect_ev(e0 + D + 1, 1, K_PRESS);
      expect_ev(e0 + D + 1 + H, 1, K_LONG);
      wait_until(e0 + D);
      check_vec("t1_pressed_early", pressed, 2'b00);
      wait_until(e0 + D + 1);
      check_vec("t1_pressed", pressed, 2'b10);
      check_vec("t1_press_pulse", press_pulse, 2'b10);
      wait_until(e0 + D + 2);
      check_vec("t1_press_pulse_drop", press_pulse, 2'b00);
      check_vec("t1_pressed_hold", pressed, 2'b10);

      // Release with a one-sample bounce
      wait_until(e0 + D + 1 + 12);
      key_n[1] = 1'b1;
      a = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      key_n[1] = 1'b0;
      @(negedge clk);
      key_n[1] = 1'b1;
      f = cyc + 1;
      expect_ev(f + D + 1, 1, K_REL);
      while (cyc < f + D) begin
         check_vec("t3_pressed_through_glitch", pressed, 2'b10);
         @(negedge clk);
      end
      wait_until(f + D + 1);
      check_vec("t3_released", pressed, 2'b00);

      // Short bounce on key 0 is rejected
      repeat (3) @(negedge clk);
      key_n[0] = 1'b0;
      repeat (3) @(negedge clk);
      key_n[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check_vec("t2_bounce_pressed", pressed, 2'b00);
         @(negedge clk);
      end

      // Reset while key 1 is held
      key_n[1] = 1'b0;
      e0 = cyc + 1;
      expect_ev(e0 + D + 1, 1, K_PRESS);
      wait_until(e0 + D + 3);
      check_vec("t5_pressed_before_reset", pressed, 2'b10);
      reset = 1'b1;
      r = cyc + 1;
      @(negedge clk);
      check_vec("t5_reset_pressed", pressed, 2'b00);
      check_vec("t5_reset_pulses", press_pulse | release_pulse | long_press, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      expect_ev(r + 2 + D + 1, 1, K_PRESS);
      wait_until(r + 2 + D);
      check_vec("t5_not_yet", pressed, 2'b00);
      wait_until(r + 2 + D + 1);
      check_vec("t5_repress", pressed, 2'b10);
      wait_until(r + 9);
      key_n[1] = 1'b1;
      e = cyc + 1;
      expect_ev(e + D + 1, 1, K_REL);
      wait_until(e + D + 1);
      check_vec("t5_release", pressed, 2'b00);

      // Independent keys pressed two cycles apart, released together
      repeat (3) @(negedge clk);
      key_n[0] = 1'b0;
      e0 = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      key_n[1] = 1'b0;
      expect_ev(e0 + D + 1, 0, K_PRESS);
      expect_ev(e0 + D + 3, 1, K_PRESS);
      expect_ev(e0 + D + 1 + H, 0, K_LONG);
      expect_ev(e0 + D + 3 + H, 1, K_LONG);
      wait_until(e0 + D + 1);
      check_vec("t6_key0_only", pressed, 2'b01);
      wait_until(e0 + D + 3);
      check_vec("t6_both", pressed, 2'b11);
      wait_until(e0 + 20);
      key_n = 2'b11;
      e = cyc + 1;
      expect_ev(e + D + 1, 0, K_REL);
      expect_ev(e + D + 1, 1, K_REL);
      wait_until(e + D);
      check_vec("t6_still_held", pressed, 2'b11);
      wait_until(e + D + 1);
      check_vec("t6_released", pressed, 2'b00);

      wait_until(cyc + 6);
      while (exp_q.size() != 0) begin
         ev_t m;
         m = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_pulse actual=none required cyc=%0d key=%0d kind=%0d", m.cyc, m.key, m.kind);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
